// File: rtl/robot_motor_driver.sv
// robot_motor_driver: two H-bridge motor FSMs sharing one PWM, with dead-time on direction reversal.
// Optional macro SENSOR_STOP_EN: forward-commanded motors brake while obstacle sensor S=1.
module robot_motor_driver #(
    parameter int DEAD_CYC = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       M1_1,
    input  logic       M1_0,
    input  logic       M2_1,
    input  logic       M2_0,
    input  logic       S,
    input  logic [3:0] duty,
    output logic       H1_A,
    output logic       H1_B,
    output logic       H2_A,
    output logic       H2_B,
    output logic [1:0] dead
);
    typedef enum logic [2:0] {COAST, FWD, REV, BRAKE, DEAD} state_t;
    localparam logic [3:0] DEAD_LD = 4'(DEAD_CYC - 1);
    logic [3:0] r_cnt;
    logic [3:0] r_duty_q;
    logic       w_pwm;
    logic       w_stop;
    logic [3:0] w_cmd;
    logic [1:0] w_a;
    logic [1:0] w_b;
    logic [1:0] w_dead;
`ifdef SENSOR_STOP_EN
    assign w_stop = S;
`else
    logic w_unused;
    assign w_unused = S;
    assign w_stop   = 1'b0;
`endif
    // duty only takes effect at period boundaries so a period is never split
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_duty_q <= '0;
        end else begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) r_duty_q <= duty;
        end
    end
    assign w_pwm = (r_cnt < r_duty_q) || (r_duty_q == 4'd15);
    assign w_cmd = {M2_1, M2_0, M1_1, M1_0};
    for (genvar g = 0; g < 2; g++) begin : g_motor
        state_t     r_state;
        state_t     w_next;
        state_t     w_req;
        logic [1:0] w_c;
        logic [3:0] r_dcnt;
        logic [3:0] w_dcnt;
        logic       r_a;
        logic       r_b;
        logic       r_dead;
        assign w_c   = w_cmd[2*g +: 2];
        assign w_req = (w_c == 2'b01) ? (w_stop ? BRAKE : FWD) :
                       (w_c == 2'b10) ? REV :
                       (w_c == 2'b11) ? BRAKE : COAST;
        always_comb begin
            w_next = w_req;
            w_dcnt = r_dcnt;
            case (r_state)
                FWD: if (w_req == REV) begin
                    w_next = DEAD;
                    w_dcnt = DEAD_LD;
                end
                REV: if (w_req == FWD) begin
                    w_next = DEAD;
                    w_dcnt = DEAD_LD;
                end
                DEAD: if (r_dcnt != 4'd0) begin
                    w_next = DEAD;
                    w_dcnt = r_dcnt - 4'd1;
                end
                default: ;
            endcase
        end
        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= COAST;
                r_dcnt  <= '0;
                r_a     <= 1'b0;
                r_b     <= 1'b0;
                r_dead  <= 1'b0;
            end else begin
                r_state <= w_next;
                r_dcnt  <= w_dcnt;
                r_a     <= (r_state == BRAKE) || ((r_state == FWD) && w_pwm);
                r_b     <= (r_state == BRAKE) || ((r_state == REV) && w_pwm);
                r_dead  <= (r_state == DEAD);
            end
        end
        assign w_a[g]    = r_a;
        assign w_b[g]    = r_b;
        assign w_dead[g] = r_dead;
    end
    assign H1_A = w_a[0];
    assign H1_B = w_b[0];
    assign H2_A = w_a[1];
    assign H2_B = w_b[1];
    assign dead = w_dead;
endmodule

// File: tb/tb_robot_motor_driver.sv
// tb_robot_motor_driver: directed vector table plus PWM, dead-time and reset sequences.
module tb_robot_motor_driver;
    logic       clk = 1'b0;
    logic       reset;
    logic       M1_1, M1_0, M2_1, M2_0, S;
    logic [3:0] duty;
    logic       H1_A, H1_B, H2_A, H2_B;
    logic [1:0] dead;
    int         checks = 0;
    int         failures = 0;

    typedef struct {
        logic [1:0] m1;
        logic [1:0] m2;
        logic       s;
        int         cyc;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[20];
    int   per[4] = '{8, 4, 12, 15};

`ifdef SENSOR_STOP_EN
    localparam logic [5:0] E_SENSE = 6'b1101_00;
`else
    localparam logic [5:0] E_SENSE = 6'b1001_00;
`endif

    robot_motor_driver #(.DEAD_CYC(4)) dut (
        .clk(clk), .reset(reset),
        .M1_1(M1_1), .M1_0(M1_0), .M2_1(M2_1), .M2_0(M2_0),
        .S(S), .duty(duty),
        .H1_A(H1_A), .H1_B(H1_B), .H2_A(H2_A), .H2_B(H2_B),
        .dead(dead)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", nm, act, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {H1_A, H1_B, H2_A, H2_B, dead};
    endfunction

    task automatic cmd(input logic [1:0] m1, input logic [1:0] m2, input logic s);
        {M1_1, M1_0} = m1;
        {M2_1, M2_0} = m2;
        S = s;
    endtask

    initial begin
        // {h1a,h1b,h2a,h2b,dead[1],dead[0]}, pwm held constant high (duty 15)
        tbl[0]  = '{2'b00, 2'b00, 1'b0, 2, 6'b0000_00};
        tbl[1]  = '{2'b01, 2'b00, 1'b0, 2, 6'b1000_00};
        tbl[2]  = '{2'b01, 2'b10, 1'b0, 2, 6'b1001_00};
        tbl[3]  = '{2'b11, 2'b10, 1'b0, 2, 6'b1101_00};
        tbl[4]  = '{2'b00, 2'b00, 1'b0, 2, 6'b0000_00};
        tbl[5]  = '{2'b01, 2'b10, 1'b0, 2, 6'b1001_00};
        tbl[6]  = '{2'b10, 2'b01, 1'b0, 1, 6'b1001_00};
        tbl[7]  = '{2'b10, 2'b01, 1'b0, 1, 6'b0000_11};
        tbl[8]  = '{2'b10, 2'b01, 1'b0, 3, 6'b0000_11};
        tbl[9]  = '{2'b10, 2'b01, 1'b0, 1, 6'b0110_00};
        tbl[10] = '{2'b00, 2'b00, 1'b0, 2, 6'b0000_00};
        tbl[11] = '{2'b01, 2'b10, 1'b1, 2, E_SENSE};
        tbl[12] = '{2'b01, 2'b10, 1'b0, 2, 6'b1001_00};
        tbl[13] = '{2'b00, 2'b11, 1'b0, 2, 6'b0011_00};
        tbl[14] = '{2'b01, 2'b00, 1'b0, 1, 6'b0011_00};
        tbl[15] = '{2'b01, 2'b00, 1'b0, 1, 6'b1000_00};
        tbl[16] = '{2'b10, 2'b00, 1'b0, 1, 6'b1000_00};
        tbl[17] = '{2'b10, 2'b00, 1'b0, 1, 6'b0000_01};
        tbl[18] = '{2'b11, 2'b00, 1'b0, 3, 6'b0000_01};
        tbl[19] = '{2'b11, 2'b00, 1'b0, 1, 6'b1100_00};

        reset = 1'b1;
        duty  = 4'd8;
        cmd(2'b01, 2'b00, 1'b0);
        tick(2);
        chk("reset_state", outs(), 6'b0000_00);
        reset = 1'b0;
        tick(16);
        chk("pwm_before_wrap", {H1_A, H1_B}, 2'b00);
        duty = 4'd4;
        for (int k = 17; k <= 80; k++) begin
            int p;
            int idx;
            tick(1);
            p   = (k - 17) / 16;
            idx = (k - 17) % 16;
            chk($sformatf("pwm_k%0d", k), {H1_A, H1_B},
                {(idx < per[p]) || (per[p] == 15), 1'b0});
            if (k == 37) duty = 4'd12;
            if (k == 50) duty = 4'd15;
        end

        for (int i = 0; i < 20; i++) begin
            cmd(tbl[i].m1, tbl[i].m2, tbl[i].s);
            tick(tbl[i].cyc);
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end

        cmd(2'b01, 2'b10, 1'b0);
        tick(2);
        chk("pre_rev", outs(), 6'b1001_00);
        cmd(2'b10, 2'b01, 1'b0);
        tick(2);
        chk("mid_dead", outs(), 6'b0000_11);
        reset = 1'b1;
        tick(1);
        chk("reset_in_dead", outs(), 6'b0000_00);
        reset = 1'b0;
        cmd(2'b11, 2'b11, 1'b0);
        tick(1);
        chk("post_reset_lat", outs(), 6'b0000_00);
        tick(1);
        chk("post_reset_brake", outs(), 6'b1111_00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
